// File: rtl/apes_adc_mon.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apes_adc_mon : ADC sweep monitor, 4-sweep boxcar average + sticky limit alarms
// Rev 1.0
// ----------------------------------------------------------------------------
module apes_adc_mon (
  input  logic        clk,
  input  logic        rst,
  input  logic        regw_pls,
  input  logic [8:0]  Lcla,
  input  logic [31:0] Lcld,
  input  logic        adc_int,
  input  logic [11:0] val_adc0,
  input  logic [11:0] val_adc1,
  input  logic [11:0] val_adc2,
  input  logic [11:0] val_adc3,
  input  logic [11:0] val_adc4,
  input  logic [11:0] val_adc5,
  input  logic [11:0] val_adc6,
  input  logic [11:0] val_adc7,
  output logic [11:0] avg_ch0,
  output logic [11:0] avg_ch1,
  output logic [11:0] avg_ch2,
  output logic [11:0] avg_ch3,
  output logic [11:0] avg_ch4,
  output logic [11:0] avg_ch5,
  output logic [11:0] avg_ch6,
  output logic [11:0] avg_ch7,
  output logic [7:0]  alm_hi,
  output logic [7:0]  alm_lo,
  output logic        mon_int,
  output logic [31:0] mon_cs_rg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SETTLE = 2'b01,
    S_PROC   = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  localparam logic [8:0] C_CTL_ADDR = 9'h020;

  state_t      state_q, state_d;
  logic        adc_int_dly_q, adc_int_dly_d;
  logic        en_q, en_d, ien_q, ien_d;
  logic [1:0]  settle_q, settle_d;
  logic [2:0]  ch_q, ch_d;
  logic [1:0]  sweep_cnt_q, sweep_cnt_d;
  logic [7:0]  alm_hi_q, alm_hi_d, alm_lo_q, alm_lo_d;
  logic        mon_int_q, mon_int_d, ovr_q, ovr_d;
  logic        new_alm_q, new_alm_d;
  logic [13:0] sum_q [8];
  logic [13:0] sum_d [8];
  logic [11:0] avg_q [8];
  logic [11:0] avg_d [8];
  logic [11:0] hi_q  [8];
  logic [11:0] hi_d  [8];
  logic [11:0] lo_q  [8];
  logic [11:0] lo_d  [8];

  logic [11:0] w_val [8];
  logic        w_sweep_pls;
  logic        w_wr_ctl, w_wr_lim;
  logic [2:0]  w_lim_idx;
  logic [13:0] w_total;
  logic [11:0] w_avg;
  logic        w_unused;

  assign w_val[0] = val_adc0;
  assign w_val[1] = val_adc1;
  assign w_val[2] = val_adc2;
  assign w_val[3] = val_adc3;
  assign w_val[4] = val_adc4;
  assign w_val[5] = val_adc5;
  assign w_val[6] = val_adc6;
  assign w_val[7] = val_adc7;

  assign w_sweep_pls = adc_int & ~adc_int_dly_q;
  assign w_wr_ctl    = regw_pls && (Lcla == C_CTL_ADDR);
  // Limit block 0x040..0x05C, word aligned
  assign w_wr_lim    = regw_pls && (Lcla[8:5] == 4'b0010) && (Lcla[1:0] == 2'b00);
  assign w_lim_idx   = Lcla[4:2];
  assign w_total     = sum_q[ch_q] + {2'b00, w_val[ch_q]};
  assign w_avg       = w_total[13:2];
  assign w_unused    = ^{Lcld[29:28], Lcld[15:12]};

  always_comb begin
    state_d       = state_q;
    adc_int_dly_d = adc_int;
    en_d          = en_q;
    ien_d         = ien_q;
    settle_d      = settle_q;
    ch_d          = ch_q;
    sweep_cnt_d   = sweep_cnt_q;
    alm_hi_d      = alm_hi_q;
    alm_lo_d      = alm_lo_q;
    mon_int_d     = mon_int_q;
    ovr_d         = ovr_q;
    new_alm_d     = new_alm_q;
    for (int i = 0; i < 8; i++) begin
      sum_d[i] = sum_q[i];
      avg_d[i] = avg_q[i];
      hi_d[i]  = hi_q[i];
      lo_d[i]  = lo_q[i];
    end

    // Clears are applied first so any set below in the same clock wins
    if (w_wr_ctl) begin
      en_d  = Lcld[0];
      ien_d = Lcld[1];
      if (Lcld[30]) begin
        alm_hi_d = '0;
        alm_lo_d = '0;
      end
      if (Lcld[31]) begin
        mon_int_d = 1'b0;
        ovr_d     = 1'b0;
      end
    end
    if (w_wr_lim) begin
      hi_d[w_lim_idx] = Lcld[27:16];
      lo_d[w_lim_idx] = Lcld[11:0];
    end

    if (!en_q) begin
      state_d     = S_IDLE;
      sweep_cnt_d = '0;
      for (int i = 0; i < 8; i++) sum_d[i] = '0;
    end else begin
      if (w_sweep_pls && (state_q != S_IDLE)) ovr_d = 1'b1;
      case (state_q)
        S_IDLE: begin
          if (w_sweep_pls) begin
            settle_d  = 2'd3;
            new_alm_d = 1'b0;
            state_d   = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_q == 2'd0) begin
            ch_d    = 3'd0;
            state_d = S_PROC;
          end else begin
            settle_d = settle_q - 2'd1;
          end
        end
        S_PROC: begin
          if (sweep_cnt_q != 2'd3) begin
            sum_d[ch_q] = w_total;
          end else begin
            avg_d[ch_q] = w_avg;
            sum_d[ch_q] = '0;
            if (w_avg > hi_q[ch_q]) begin
              alm_hi_d[ch_q] = 1'b1;
              if (!alm_hi_q[ch_q]) new_alm_d = 1'b1;
            end
            if (w_avg < lo_q[ch_q]) begin
              alm_lo_d[ch_q] = 1'b1;
              if (!alm_lo_q[ch_q]) new_alm_d = 1'b1;
            end
          end
          if (ch_q == 3'd7) state_d = S_DONE;
          else              ch_d    = ch_q + 3'd1;
        end
        S_DONE: begin
          sweep_cnt_d = sweep_cnt_q + 2'd1;
          if ((sweep_cnt_q == 2'd3) && new_alm_q && ien_q) mon_int_d = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      adc_int_dly_q <= 1'b0;
      en_q          <= 1'b0;
      ien_q         <= 1'b0;
      settle_q      <= '0;
      ch_q          <= '0;
      sweep_cnt_q   <= '0;
      alm_hi_q      <= '0;
      alm_lo_q      <= '0;
      mon_int_q     <= 1'b0;
      ovr_q         <= 1'b0;
      new_alm_q     <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        sum_q[i] <= '0;
        avg_q[i] <= '0;
        hi_q[i]  <= 12'hFFF;
        lo_q[i]  <= 12'h000;
      end
    end else begin
      state_q       <= state_d;
      adc_int_dly_q <= adc_int_dly_d;
      en_q          <= en_d;
      ien_q         <= ien_d;
      settle_q      <= settle_d;
      ch_q          <= ch_d;
      sweep_cnt_q   <= sweep_cnt_d;
      alm_hi_q      <= alm_hi_d;
      alm_lo_q      <= alm_lo_d;
      mon_int_q     <= mon_int_d;
      ovr_q         <= ovr_d;
      new_alm_q     <= new_alm_d;
      for (int i = 0; i < 8; i++) begin
        sum_q[i] <= sum_d[i];
        avg_q[i] <= avg_d[i];
        hi_q[i]  <= hi_d[i];
        lo_q[i]  <= lo_d[i];
      end
    end
  end

  assign avg_ch0   = avg_q[0];
  assign avg_ch1   = avg_q[1];
  assign avg_ch2   = avg_q[2];
  assign avg_ch3   = avg_q[3];
  assign avg_ch4   = avg_q[4];
  assign avg_ch5   = avg_q[5];
  assign avg_ch6   = avg_q[6];
  assign avg_ch7   = avg_q[7];
  assign alm_hi    = alm_hi_q;
  assign alm_lo    = alm_lo_q;
  assign mon_int   = mon_int_q;
  assign mon_cs_rg = {mon_int_q, ovr_q, 6'd0, alm_hi_q, alm_lo_q, 2'd0,
                      state_q, sweep_cnt_q, ien_q, en_q};

endmodule
`default_nettype wire

// File: tb/tb_apes_adc_mon.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_apes_adc_mon : randomized self-checking bench with a sweep-level reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_apes_adc_mon;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        regw_pls = 1'b0;
  logic        adc_int = 1'b0;
  logic [8:0]  Lcla = '0;
  logic [31:0] Lcld = '0;
  logic [11:0] vin   [8];
  logic [11:0] avg_w [8];
  logic [7:0]  alm_hi, alm_lo;
  logic        mon_int;
  logic [31:0] mon_cs_rg;

  int checks = 0;
  int failures = 0;

  // Reference model state: one entry per channel, updated once per completed sweep
  int   m_sum [8];
  int   m_avg [8];
  int   m_hi  [8];
  int   m_lo  [8];
  int   m_cnt;
  logic [7:0] m_ahi, m_alo;
  logic m_mon, m_ovr, m_ien;

  apes_adc_mon dut (
    .clk(clk), .rst(rst), .regw_pls(regw_pls), .Lcla(Lcla), .Lcld(Lcld), .adc_int(adc_int),
    .val_adc0(vin[0]), .val_adc1(vin[1]), .val_adc2(vin[2]), .val_adc3(vin[3]),
    .val_adc4(vin[4]), .val_adc5(vin[5]), .val_adc6(vin[6]), .val_adc7(vin[7]),
    .avg_ch0(avg_w[0]), .avg_ch1(avg_w[1]), .avg_ch2(avg_w[2]), .avg_ch3(avg_w[3]),
    .avg_ch4(avg_w[4]), .avg_ch5(avg_w[5]), .avg_ch6(avg_w[6]), .avg_ch7(avg_w[7]),
    .alm_hi(alm_hi), .alm_lo(alm_lo), .mon_int(mon_int), .mon_cs_rg(mon_cs_rg)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic void model_reset();
    for (int c = 0; c < 8; c++) begin
      m_sum[c] = 0; m_avg[c] = 0; m_hi[c] = 12'hFFF; m_lo[c] = 0;
    end
    m_cnt = 0; m_ahi = '0; m_alo = '0; m_mon = 1'b0; m_ovr = 1'b0; m_ien = 1'b0;
  endfunction

  // Every 4th sweep publishes floor(sum/4) and checks it against the limits
  function automatic void model_pass();
    bit wrap;
    bit newly;
    int a;
    wrap = (m_cnt == 3);
    newly = 1'b0;
    for (int c = 0; c < 8; c++) begin
      m_sum[c] += int'(vin[c]);
      if (wrap) begin
        a = m_sum[c] / 4;
        m_avg[c] = a;
        m_sum[c] = 0;
        if (a > m_hi[c]) begin
          if (!m_ahi[c]) newly = 1'b1;
          m_ahi[c] = 1'b1;
        end
        if (a < m_lo[c]) begin
          if (!m_alo[c]) newly = 1'b1;
          m_alo[c] = 1'b1;
        end
      end
    end
    m_cnt = (m_cnt + 1) % 4;
    if (wrap && newly && m_ien) m_mon = 1'b1;
  endfunction

  task automatic wr(input logic [8:0] a, input logic [31:0] d);
    @(negedge clk); regw_pls = 1'b1; Lcla = a; Lcld = d;
    @(negedge clk); regw_pls = 1'b0;
  endtask

  task automatic set_ctl(input logic en, input logic ien, input logic c_alm, input logic c_int);
    wr(9'h020, {c_int, c_alm, 28'd0, ien, en});
    m_ien = ien;
    if (c_alm) begin m_ahi = '0; m_alo = '0; end
    if (c_int) begin m_mon = 1'b0; m_ovr = 1'b0; end
  endtask

  task automatic set_lim(input int ch, input logic [11:0] hi, input logic [11:0] lo);
    wr(9'h040 + 9'(4 * ch), {4'd0, hi, 4'd0, lo});
    m_hi[ch] = int'(hi); m_lo[ch] = int'(lo);
  endtask

  task automatic set_vin(input logic [11:0] v);
    for (int c = 0; c < 8; c++) vin[c] = v;
  endtask

  task automatic rand_vin();
    for (int c = 0; c < 8; c++) vin[c] = 12'($urandom_range(0, 4095));
  endtask

  task automatic sweep_end();
    @(negedge clk); adc_int = 1'b0;
    @(negedge clk);
  endtask

  // Full pass: edge at cycle T, returns after lowering adc_int once back in IDLE
  task automatic sweep();
    @(negedge clk); adc_int = 1'b1;
    repeat (14) @(posedge clk);
    #1; model_pass();
    sweep_end();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 8; c++)
      begin checks++; if (avg_w[c] !== 12'd0) begin failures++; $display("FAIL reset_avg%0d: got %h expected 000", c, avg_w[c]); end end
    checks++; if (alm_hi !== 8'd0) begin failures++; $display("FAIL reset_alm_hi: got %h expected 00", alm_hi); end
    checks++; if (alm_lo !== 8'd0) begin failures++; $display("FAIL reset_alm_lo: got %h expected 00", alm_lo); end
    checks++; if (mon_int !== 1'b0) begin failures++; $display("FAIL reset_mon_int: got %b expected 0", mon_int); end
    checks++; if (mon_cs_rg !== 32'd0) begin failures++; $display("FAIL reset_cs: got %h expected 00000000", mon_cs_rg); end
  endtask

  task automatic test_averaging();
    int vals[4] = '{100, 200, 300, 401};
    int old;
    old = m_avg[3];
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      rand_vin(); vin[3] = 12'(vals[s]);
      sweep();
      checks++; if (avg_w[3] !== 12'(old)) begin failures++; $display("FAIL avg_hold_s%0d: got %h expected %h", s, avg_w[3], 12'(old)); end
    end
    rand_vin(); vin[3] = 12'(vals[3]);
    @(negedge clk); adc_int = 1'b1;
    repeat (8) @(posedge clk); #1;
    checks++; if (avg_w[3] !== 12'(old)) begin failures++; $display("FAIL avg_early: got %h expected %h", avg_w[3], 12'(old)); end
    @(posedge clk); #1;
    checks++; if (avg_w[3] !== 12'h0FA) begin failures++; $display("FAIL avg_publish: got %h expected 0fa", avg_w[3]); end
    repeat (5) @(posedge clk); #1;
    model_pass();
    checks++; if (mon_cs_rg[3:2] !== 2'd0) begin failures++; $display("FAIL avg_sweep_cnt: got %0d expected 0", mon_cs_rg[3:2]); end
    for (int c = 0; c < 8; c++)
      begin checks++; if (avg_w[c] !== 12'(m_avg[c])) begin failures++; $display("FAIL avg_ch%0d: got %h expected %h", c, avg_w[c], 12'(m_avg[c])); end end
    sweep_end();
  endtask

  task automatic test_limits_int();
    set_ctl(1'b1, 1'b1, 1'b1, 1'b1);
    set_lim(5, 12'h800, 12'h100);
    set_vin(12'h900);
    repeat (3) sweep();
    checks++; if (alm_hi !== 8'h00) begin failures++; $display("FAIL lim_pre_alm: got %h expected 00", alm_hi); end
    @(negedge clk); adc_int = 1'b1;
    repeat (13) @(posedge clk); #1;
    checks++; if (mon_int !== 1'b0 || mon_cs_rg[5:4] !== 2'd3) begin failures++; $display("FAIL lim_t13: got mon_int=%b state=%0d expected 0/3", mon_int, mon_cs_rg[5:4]); end
    @(posedge clk); #1;
    model_pass();
    checks++; if (mon_int !== 1'b1 || mon_int !== m_mon) begin failures++; $display("FAIL lim_mon_int: got %b expected 1", mon_int); end
    checks++; if (alm_hi !== 8'h20 || alm_hi !== m_ahi) begin failures++; $display("FAIL lim_alm_hi: got %h expected 20", alm_hi); end
    checks++; if (mon_cs_rg[5:4] !== 2'd0) begin failures++; $display("FAIL lim_idle_t14: got %0d expected 0", mon_cs_rg[5:4]); end
    sweep_end();
  endtask

  task automatic test_clear_vs_set();
    set_vin(12'h900);
    repeat (3) sweep();
    @(negedge clk); adc_int = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk); regw_pls = 1'b1; Lcla = 9'h020; Lcld = 32'h4000_0003;
    @(negedge clk); regw_pls = 1'b0;
    checks++; if (alm_hi !== 8'h20) begin failures++; $display("FAIL clr_vs_set: got %h expected 20", alm_hi); end
    repeat (3) @(posedge clk); #1;
    model_pass();
    sweep_end();
    checks++; if (mon_int !== 1'b1) begin failures++; $display("FAIL clr_pre_mon: got %b expected 1", mon_int); end
    set_ctl(1'b1, 1'b1, 1'b0, 1'b1);
    checks++; if (mon_int !== 1'b0 || mon_cs_rg[31] !== 1'b0) begin failures++; $display("FAIL clr_mon_int: got %b expected 0", mon_int); end
    checks++; if (alm_hi !== m_ahi) begin failures++; $display("FAIL clr_keep_alm: got %h expected %h", alm_hi, m_ahi); end
  endtask

  task automatic test_equal_limit();
    set_ctl(1'b1, 1'b1, 1'b1, 1'b1);
    set_lim(6, 12'h7FF, 12'h801);
    set_vin(12'h800);
    repeat (4) sweep();
    checks++; if (avg_w[5] !== 12'h800) begin failures++; $display("FAIL eq_avg5: got %h expected 800", avg_w[5]); end
    checks++; if (alm_hi !== 8'h40 || alm_hi !== m_ahi) begin failures++; $display("FAIL eq_alm_hi: got %h expected 40", alm_hi); end
    checks++; if (alm_lo !== 8'h40 || alm_lo !== m_alo) begin failures++; $display("FAIL eq_alm_lo: got %h expected 40", alm_lo); end
    checks++; if (mon_int !== m_mon) begin failures++; $display("FAIL eq_mon_int: got %b expected %b", mon_int, m_mon); end
    set_ctl(1'b1, 1'b1, 1'b1, 1'b1);
    set_lim(6, 12'hFFF, 12'h000);
  endtask

  task automatic test_overrun();
    rand_vin();
    @(negedge clk); adc_int = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk); adc_int = 1'b0;
    @(negedge clk); adc_int = 1'b1;
    m_ovr = 1'b1;
    @(posedge clk); #1;
    checks++; if (mon_cs_rg[30] !== m_ovr) begin failures++; $display("FAIL ovr_set: got %b expected 1", mon_cs_rg[30]); end
    repeat (7) @(posedge clk); #1;
    model_pass();
    checks++; if (mon_cs_rg[5:4] !== 2'd0 || mon_cs_rg[3:2] !== 2'(m_cnt)) begin failures++; $display("FAIL ovr_once: got state=%0d cnt=%0d expected 0/%0d", mon_cs_rg[5:4], mon_cs_rg[3:2], m_cnt); end
    repeat (20) @(posedge clk); #1;
    checks++; if (mon_cs_rg[5:4] !== 2'd0 || mon_cs_rg[3:2] !== 2'(m_cnt)) begin failures++; $display("FAIL ovr_level: got state=%0d cnt=%0d expected 0/%0d", mon_cs_rg[5:4], mon_cs_rg[3:2], m_cnt); end
    sweep_end();
    set_ctl(1'b1, m_ien, 1'b0, 1'b1);
    checks++; if (mon_cs_rg[30] !== 1'b0) begin failures++; $display("FAIL ovr_clear: got %b expected 0", mon_cs_rg[30]); end
  endtask

  task automatic test_back_to_back();
    rand_vin();
    @(negedge clk); adc_int = 1'b1;
    repeat (13) @(posedge clk);
    @(negedge clk); adc_int = 1'b0;
    @(posedge clk); #1;
    model_pass();
    checks++; if (mon_cs_rg[5:4] !== 2'd0) begin failures++; $display("FAIL b2b_idle: got %0d expected 0", mon_cs_rg[5:4]); end
    @(negedge clk); adc_int = 1'b1;
    @(posedge clk); #1;
    checks++; if (mon_cs_rg[5:4] !== 2'd1 || mon_cs_rg[30] !== 1'b0) begin failures++; $display("FAIL b2b_accept: got state=%0d ovr=%b expected 1/0", mon_cs_rg[5:4], mon_cs_rg[30]); end
    repeat (13) @(posedge clk); #1;
    model_pass();
    checks++; if (mon_cs_rg[3:2] !== 2'(m_cnt)) begin failures++; $display("FAIL b2b_cnt: got %0d expected %0d", mon_cs_rg[3:2], m_cnt); end
    sweep_end();
  endtask

  task automatic test_disable();
    repeat (3) begin rand_vin(); sweep(); end
    @(negedge clk); adc_int = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); regw_pls = 1'b1; Lcla = 9'h020; Lcld = {30'd0, m_ien, 1'b0};
    @(negedge clk); regw_pls = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 8; c++) m_sum[c] = 0;
    m_cnt = 0;
    checks++; if (mon_cs_rg[5:4] !== 2'd0 || mon_cs_rg[3:2] !== 2'd0) begin failures++; $display("FAIL dis_idle: got state=%0d cnt=%0d expected 0/0", mon_cs_rg[5:4], mon_cs_rg[3:2]); end
    for (int c = 0; c < 8; c++)
      begin checks++; if (avg_w[c] !== 12'(m_avg[c])) begin failures++; $display("FAIL dis_hold_avg%0d: got %h expected %h", c, avg_w[c], 12'(m_avg[c])); end end
    checks++; if (alm_hi !== m_ahi || alm_lo !== m_alo || mon_int !== m_mon) begin failures++; $display("FAIL dis_hold_flags: got %h/%h/%b expected %h/%h/%b", alm_hi, alm_lo, mon_int, m_ahi, m_alo, m_mon); end
    sweep_end();
    @(negedge clk); adc_int = 1'b1;
    repeat (6) @(posedge clk); #1;
    checks++; if (mon_cs_rg[5:4] !== 2'd0 || mon_cs_rg[30] !== 1'b0) begin failures++; $display("FAIL dis_ignore: got state=%0d ovr=%b expected 0/0", mon_cs_rg[5:4], mon_cs_rg[30]); end
    sweep_end();
    set_ctl(1'b1, m_ien, 1'b0, 1'b0);
    for (int s = 0; s < 4; s++) begin
      rand_vin();
      sweep();
      for (int c = 0; c < 8; c++)
        begin checks++; if (avg_w[c] !== 12'(m_avg[c])) begin failures++; $display("FAIL dis_rearm_s%0d_avg%0d: got %h expected %h", s, c, avg_w[c], 12'(m_avg[c])); end end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      set_ctl(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
      for (int c = 0; c < 8; c++)
        set_lim(c, 12'($urandom_range(12'h400, 12'hC00)), 12'($urandom_range(12'h200, 12'hA00)));
      for (int s = 0; s < 4; s++) begin
        rand_vin();
        sweep();
        for (int c = 0; c < 8; c++)
          begin checks++; if (avg_w[c] !== 12'(m_avg[c])) begin failures++; $display("FAIL rnd%0d_s%0d_avg%0d: got %h expected %h", r, s, c, avg_w[c], 12'(m_avg[c])); end end
        checks++; if (alm_hi !== m_ahi) begin failures++; $display("FAIL rnd%0d_s%0d_alm_hi: got %h expected %h", r, s, alm_hi, m_ahi); end
        checks++; if (alm_lo !== m_alo) begin failures++; $display("FAIL rnd%0d_s%0d_alm_lo: got %h expected %h", r, s, alm_lo, m_alo); end
        checks++; if (mon_int !== m_mon) begin failures++; $display("FAIL rnd%0d_s%0d_mon_int: got %b expected %b", r, s, mon_int, m_mon); end
        checks++; if (mon_cs_rg[3:2] !== 2'(m_cnt)) begin failures++; $display("FAIL rnd%0d_s%0d_cnt: got %0d expected %0d", r, s, mon_cs_rg[3:2], m_cnt); end
      end
    end
  endtask

  task automatic test_reset_mid();
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
    rand_vin();
    @(negedge clk); adc_int = 1'b1;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    test_reset();
    @(negedge clk); rst = 1'b0; adc_int = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_defaults();
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) vin[c] = (c % 2 == 0) ? 12'hFFF : 12'h000;
    repeat (4) sweep();
    for (int c = 0; c < 8; c++)
      begin checks++; if (avg_w[c] !== 12'(m_avg[c])) begin failures++; $display("FAIL def_avg%0d: got %h expected %h", c, avg_w[c], 12'(m_avg[c])); end end
    checks++; if (alm_hi !== 8'h00 || alm_lo !== 8'h00) begin failures++; $display("FAIL def_limits: got hi=%h lo=%h expected 00/00", alm_hi, alm_lo); end
    checks++; if (mon_int !== 1'b0) begin failures++; $display("FAIL def_mon_int: got %b expected 0", mon_int); end
  endtask

  initial begin
    set_vin(12'h000);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_averaging();
    test_limits_int();
    test_clear_vs_set();
    test_equal_limit();
    test_overrun();
    test_back_to_back();
    test_disable();
    test_random();
    test_reset_mid();
    test_defaults();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
